// File: rtl/int_add_issue_arbiter.sv
// Round-robin issue arbiter in front of the shared integer adder: tracks uops through the
// adder latency and queues results with requester id/tag, using credits so the queue never overflows.
module int_add_issue_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int IMM_WIDTH   = 21,
  parameter int TAG_WIDTH   = 4,
  parameter int ADD_LATENCY = 1,
  parameter int RSP_DEPTH   = ADD_LATENCY + 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [2*NUM_REQ-1:0]            req_add_type,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_src1,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_src2,
  input  logic [IMM_WIDTH*NUM_REQ-1:0]    req_imm,
  input  logic [TAG_WIDTH*NUM_REQ-1:0]    req_tag,
  output logic                            add_uop_valid,
  output logic [1:0]                      add_type,
  output logic [DATA_WIDTH-1:0]           add_src1,
  output logic [DATA_WIDTH-1:0]           add_src2,
  output logic [IMM_WIDTH-1:0]            add_imm,
  input  logic [DATA_WIDTH-1:0]           add_value,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  output logic [DATA_WIDTH-1:0]           rsp_value
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CRED_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RSP_DEPTH);

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic [ADD_LATENCY-1:0] trk_valid_q, trk_valid_d;
  logic [ID_W-1:0]       trk_id_q [ADD_LATENCY];
  logic [ID_W-1:0]       trk_id_d [ADD_LATENCY];
  logic [TAG_WIDTH-1:0]  trk_tag_q [ADD_LATENCY];
  logic [TAG_WIDTH-1:0]  trk_tag_d [ADD_LATENCY];
  logic [DATA_WIDTH-1:0] mem_value_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_value_d [RSP_DEPTH];
  logic [ID_W-1:0]       mem_id_q [RSP_DEPTH];
  logic [ID_W-1:0]       mem_id_d [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag_q [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag_d [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CRED_W-1:0]     count_q, count_d;

  logic            fire, push, pop;
  logic [ID_W-1:0] gnt_id, idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant the first valid requester at or after rr_ptr, only while a result slot is reserved-free.
  always_comb begin
    req_ready = '0;
    fire      = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    if (!reset && credits_q != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!fire && req_valid[idx]) begin
          fire   = 1'b1;
          gnt_id = idx;
        end
      end
    end
    if (fire) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    add_uop_valid = fire;
    add_type      = '0;
    add_src1      = '0;
    add_src2      = '0;
    add_imm       = '0;
    if (fire) begin
      add_type = req_add_type[gnt_id*2 +: 2];
      add_src1 = req_src1[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      add_src2 = req_src2[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      add_imm  = req_imm[gnt_id*IMM_WIDTH +: IMM_WIDTH];
    end
  end

  assign push      = trk_valid_q[ADD_LATENCY-1];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_id    = mem_id_q[rd_ptr_q];
  assign rsp_tag   = mem_tag_q[rd_ptr_q];
  assign rsp_value = mem_value_q[rd_ptr_q];

  always_comb begin
    rr_ptr_d  = fire ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : rr_ptr_q;

    credits_d = credits_q;
    if (fire && !pop)      credits_d = credits_q - CRED_W'(1);
    else if (pop && !fire) credits_d = credits_q + CRED_W'(1);

    trk_valid_d    = trk_valid_q;
    trk_id_d       = trk_id_q;
    trk_tag_d      = trk_tag_q;
    trk_valid_d[0] = fire;
    trk_id_d[0]    = gnt_id;
    trk_tag_d[0]   = fire ? req_tag[gnt_id*TAG_WIDTH +: TAG_WIDTH] : '0;
    for (int i = 1; i < ADD_LATENCY; i++) begin
      trk_valid_d[i] = trk_valid_q[i-1];
      trk_id_d[i]    = trk_id_q[i-1];
      trk_tag_d[i]   = trk_tag_q[i-1];
    end

    // The adder result is valid exactly when the last tracker stage is, so capture it then.
    mem_value_d = mem_value_q;
    mem_id_d    = mem_id_q;
    mem_tag_d   = mem_tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      mem_value_d[wr_ptr_q] = add_value;
      mem_id_d[wr_ptr_q]    = trk_id_q[ADD_LATENCY-1];
      mem_tag_d[wr_ptr_q]   = trk_tag_q[ADD_LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CRED_W'(1);
      2'b01:   count_d = count_q - CRED_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      credits_q   <= CRED_MAX;
      trk_valid_q <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) begin
        trk_id_q[i]  <= '0;
        trk_tag_q[i] <= '0;
      end
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_value_q[i] <= '0;
        mem_id_q[i]    <= '0;
        mem_tag_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      trk_valid_q <= trk_valid_d;
      trk_id_q    <= trk_id_d;
      trk_tag_q   <= trk_tag_d;
      mem_value_q <= mem_value_d;
      mem_id_q    <= mem_id_d;
      mem_tag_q   <= mem_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (credits_q <= CRED_MAX);
      assert (!(fire && !pop && credits_q == '0));
      assert (!(push && !pop && count_q == CRED_MAX));
    end
  end

endmodule

// File: tb/tb_int_add_issue_arbiter.sv
// Directed bench for int_add_issue_arbiter with a one-cycle behavioural model of the adder.
module tb_int_add_issue_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int IW      = 21;
  localparam int TW      = 4;
  localparam logic [1:0] T_ADD  = 2'd0;
  localparam logic [1:0] T_SUB  = 2'd1;
  localparam logic [1:0] T_ADDI = 2'd2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [2*NUM_REQ-1:0]    req_add_type = '0;
  logic [DW*NUM_REQ-1:0]   req_src1 = '0;
  logic [DW*NUM_REQ-1:0]   req_src2 = '0;
  logic [IW*NUM_REQ-1:0]   req_imm = '0;
  logic [TW*NUM_REQ-1:0]   req_tag = '0;
  logic                    add_uop_valid;
  logic [1:0]              add_type;
  logic [DW-1:0]           add_src1, add_src2;
  logic [IW-1:0]           add_imm;
  logic [DW-1:0]           add_value = '0;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b1;
  logic                    rsp_id;
  logic [TW-1:0]           rsp_tag;
  logic [DW-1:0]           rsp_value;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  int_add_issue_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_add_type(req_add_type),
    .req_src1(req_src1), .req_src2(req_src2), .req_imm(req_imm), .req_tag(req_tag),
    .add_uop_valid(add_uop_valid), .add_type(add_type), .add_src1(add_src1),
    .add_src2(add_src2), .add_imm(add_imm), .add_value(add_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_value(rsp_value)
  );

  // Adder stand-in: one register stage, SUB two's complement, ADDI zero-extends the immediate.
  always @(posedge clk) begin
    case (add_type)
      T_ADD:   add_value <= add_src1 + add_src2;
      T_SUB:   add_value <= add_src1 - add_src2;
      T_ADDI:  add_value <= add_src1 + DW'(add_imm);
      default: add_value <= '0;
    endcase
  end

  task automatic set_req(input int i, input logic v, input logic [1:0] t, input logic [DW-1:0] s1,
                         input logic [DW-1:0] s2, input logic [IW-1:0] imm, input logic [TW-1:0] tag);
    req_valid[i]          = v;
    req_add_type[2*i +: 2] = t;
    req_src1[DW*i +: DW]  = s1;
    req_src2[DW*i +: DW]  = s2;
    req_imm[IW*i +: IW]   = imm;
    req_tag[TW*i +: TW]   = tag;
  endtask

  task automatic test_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, T_ADD, 32'd9, 32'd9, '0, 4'd1);
    set_req(1, 1'b1, T_ADD, 32'd8, 32'd8, '0, 4'd2);
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_ready got=%b exp=00", req_ready); end
    vectors++; if (add_uop_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_uop_valid got=%b exp=0", add_uop_valid); end
    vectors++; if (add_src1 !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_src1 got=%h exp=0", add_src1); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rel_rsp_valid got=%b exp=0", rsp_valid); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_rel_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_val [4];
    logic [TW-1:0] exp_tag [4];
    logic          exp_id  [4];
    int n0 = 0;
    int n1 = 0;
    int g;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        set_req(0, 1'b1, T_ADD, 32'(100 + n0), 32'd1, '0, 4'(n0));
        set_req(1, 1'b1, T_ADD, 32'(200 + n1), 32'd2, '0, 4'(8 + n1));
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 4) begin
        g = c % 2;
        vectors++; if (req_ready !== 2'(1 << g)) begin miscompares++; $display("[TB] FAIL b2b_grant c=%0d got=%b exp=%b", c, req_ready, 2'(1 << g)); end
        exp_id[c] = (g == 1);
        if (g == 0) begin exp_val[c] = 32'(101 + n0); exp_tag[c] = 4'(n0); n0++; end
        else        begin exp_val[c] = 32'(202 + n1); exp_tag[c] = 4'(8 + n1); n1++; end
      end else begin
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL b2b_idle c=%0d got=%b exp=00", c, req_ready); end
      end
      if (c >= 2) begin
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rsp_valid c=%0d got=%b exp=1", c, rsp_valid); end
        vectors++; if (rsp_id !== exp_id[c-2]) begin miscompares++; $display("[TB] FAIL b2b_id c=%0d got=%0d exp=%0d", c, rsp_id, exp_id[c-2]); end
        vectors++; if (rsp_tag !== exp_tag[c-2]) begin miscompares++; $display("[TB] FAIL b2b_tag c=%0d got=%0d exp=%0d", c, rsp_tag, exp_tag[c-2]); end
        vectors++; if (rsp_value !== exp_val[c-2]) begin miscompares++; $display("[TB] FAIL b2b_value c=%0d got=%h exp=%h", c, rsp_value, exp_val[c-2]); end
      end else begin
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_early_rsp c=%0d got=%b exp=0", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_single_add();
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 1'b1, T_ADD, 32'd5, 32'd7, '0, 4'd3);
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL add_grant got=%b exp=01", req_ready); end
    vectors++; if (add_uop_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_uop_valid got=%b exp=1", add_uop_valid); end
    vectors++; if (add_type !== T_ADD) begin miscompares++; $display("[TB] FAIL add_type got=%0d exp=%0d", add_type, T_ADD); end
    vectors++; if (add_src1 !== 32'd5 || add_src2 !== 32'd7) begin miscompares++; $display("[TB] FAIL add_operands got=%0d,%0d exp=5,7", add_src1, add_src2); end
    @(negedge clk);
    req_valid = '0;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_lat1 got=%b exp=0", rsp_valid); end
    @(negedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_lat2 got=%b exp=1", rsp_valid); end
    vectors++; if (rsp_value !== 32'd12) begin miscompares++; $display("[TB] FAIL add_value got=%0d exp=12", rsp_value); end
    vectors++; if (rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin miscompares++; $display("[TB] FAIL add_idtag got=%0d/%0d exp=0/3", rsp_id, rsp_tag); end
    @(negedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_value !== 32'd12) begin miscompares++; $display("[TB] FAIL add_hold got=%b/%0d exp=1/12", rsp_valid, rsp_value); end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_popped got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      set_req(0, 1'b1, T_ADD, 32'(1000 + k), 32'(k), '0, 4'(k));
      #1;
      if (c < 3) begin
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL bp_grant c=%0d got=%b exp=01", c, req_ready); end
        k++;
      end else begin
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL bp_block c=%0d got=%b exp=00", c, req_ready); end
      end
    end
    vectors++; if (rsp_valid !== 1'b1 || rsp_value !== 32'd1000) begin miscompares++; $display("[TB] FAIL bp_head got=%b/%0d exp=1/1000", rsp_valid, rsp_value); end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (r == 0) begin req_valid = '0; rsp_ready = 1'b1; end
      #1;
      if (r < 3) begin
        vectors++; if (rsp_valid !== 1'b1 || rsp_value !== 32'(1000 + 2*r) || rsp_tag !== 4'(r) || rsp_id !== 1'b0)
          begin miscompares++; $display("[TB] FAIL bp_drain r=%0d got=%b/%0d/%0d exp=1/%0d/%0d", r, rsp_valid, rsp_value, rsp_tag, 1000 + 2*r, r); end
      end else begin
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_empty got=%b exp=0", rsp_valid); end
      end
    end
  endtask

  task automatic test_sub_addi();
    rsp_ready = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, T_ADDI, 32'd1, 32'h1234_5678, 21'h1F_FFFF, 4'd9);
    set_req(1, 1'b1, T_SUB, 32'd3, 32'd5, '0, 4'd5);
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL sub_grant got=%b exp=10", req_ready); end
    vectors++; if (add_type !== T_SUB || add_src1 !== 32'd3 || add_src2 !== 32'd5) begin miscompares++; $display("[TB] FAIL sub_drive got=%0d/%0d/%0d exp=1/3/5", add_type, add_src1, add_src2); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL addi_grant got=%b exp=01", req_ready); end
    vectors++; if (add_type !== T_ADDI || add_imm !== 21'h1F_FFFF || add_src1 !== 32'd1) begin miscompares++; $display("[TB] FAIL addi_drive got=%0d/%h/%0d exp=2/1fffff/1", add_type, add_imm, add_src1); end
    @(negedge clk);
    req_valid = '0;
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_tag !== 4'd5 || rsp_value !== 32'hFFFF_FFFE)
      begin miscompares++; $display("[TB] FAIL sub_result got=%b/%0d/%0d/%h exp=1/1/5/fffffffe", rsp_valid, rsp_id, rsp_tag, rsp_value); end
    @(negedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd9 || rsp_value !== 32'h0020_0000)
      begin miscompares++; $display("[TB] FAIL addi_result got=%b/%0d/%0d/%h exp=1/0/9/00200000", rsp_valid, rsp_id, rsp_tag, rsp_value); end
    @(negedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL subaddi_empty got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_credit_edge();
    int k = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_req(0, 1'b1, T_ADD, 32'(50 + k), 32'd0, '0, 4'(k));
      #1;
      vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL cr_fill c=%0d got=%b exp=01", c, req_ready); end
      k++;
    end
    // Zero credits: a pop this cycle must not unlock a grant in the same cycle.
    @(negedge clk);
    set_req(0, 1'b1, T_ADD, 32'(50 + k), 32'd0, '0, 4'(k));
    rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL cr_zero_pop got=%b exp=00", req_ready); end
    vectors++; if (rsp_valid !== 1'b1 || rsp_value !== 32'd50) begin miscompares++; $display("[TB] FAIL cr_head0 got=%b/%0d exp=1/50", rsp_valid, rsp_value); end
    @(negedge clk);
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL cr_one_pop got=%b exp=01", req_ready); end
    vectors++; if (rsp_value !== 32'd51) begin miscompares++; $display("[TB] FAIL cr_head1 got=%0d exp=51", rsp_value); end
    k++;
    @(negedge clk);
    set_req(0, 1'b1, T_ADD, 32'(50 + k), 32'd0, '0, 4'(k));
    rsp_ready = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL cr_still_one got=%b exp=01", req_ready); end
    vectors++; if (rsp_value !== 32'd52) begin miscompares++; $display("[TB] FAIL cr_head2 got=%0d exp=52", rsp_value); end
    k++;
    @(negedge clk);
    set_req(0, 1'b1, T_ADD, 32'(50 + k), 32'd0, '0, 4'(k));
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL cr_exhausted got=%b exp=00", req_ready); end
    vectors++; if (rsp_value !== 32'd52) begin miscompares++; $display("[TB] FAIL cr_head2_hold got=%0d exp=52", rsp_value); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      #1;
      if (r < 2) begin
        vectors++; if (rsp_valid !== 1'b1 || rsp_value !== 32'(53 + r)) begin miscompares++; $display("[TB] FAIL cr_drain r=%0d got=%b/%0d exp=1/%0d", r, rsp_valid, rsp_value, 53 + r); end
      end else begin
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL cr_empty got=%b exp=0", rsp_valid); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    rsp_ready = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, T_ADD, 32'h111, 32'd0, '0, 4'd1);
    set_req(1, 1'b1, T_ADD, 32'h222, 32'd0, '0, 4'd2);
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL rif_grant1 got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL rif_grant0 got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    #1;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rif_pre_rsp got=%b exp=1", rsp_valid); end
    vectors++; if (req_ready !== 2'b00 || add_uop_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_in_reset got=%b/%b exp=00/0", req_ready, add_uop_valid); end
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 1'b1, T_ADD, 32'h500, 32'd0, '0, 4'd7);
    set_req(1, 1'b1, T_ADD, 32'h600, 32'd0, '0, 4'd6);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_flushed got=%b exp=0", rsp_valid); end
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL rif_ptr0 got=%b exp=01", req_ready); end
    @(negedge clk);
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL rif_rr1 got=%b exp=10", req_ready); end
    @(negedge clk);
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL rif_rr2 got=%b exp=01", req_ready); end
    vectors++; if (rsp_valid !== 1'b1 || rsp_value !== 32'h500 || rsp_tag !== 4'd7 || rsp_id !== 1'b0)
      begin miscompares++; $display("[TB] FAIL rif_first_rsp got=%b/%h/%0d/%0d exp=1/500/7/0", rsp_valid, rsp_value, rsp_tag, rsp_id); end
    @(negedge clk);
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL rif_credits got=%b exp=00", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_add();
    test_backpressure();
    test_sub_addi();
    test_credit_edge();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
